// File: rtl/ldtu_ofifo_secded.sv
// rtl/ldtu_ofifo_secded.sv - parametrised SECDED-protected output FIFO for the LiTe-DTU data path
module ldtu_ofifo_secded #(
   parameter int                    Nbits_data   = 32,
   parameter int                    Nbits_par    = 6,
   parameter int                    FifoDepth    = 16,
   parameter int                    bits_ptr     = 4,
   parameter logic [Nbits_data-1:0] idle_pattern = 32'hEAAAAAAA
) (
   input  logic                  CLK,
   input  logic                  reset,
   input  logic                  write_signal,
   input  logic [Nbits_data-1:0] data_in,
   input  logic                  read_signal,
   input  logic [bits_ptr:0]     af_threshold,
   input  logic [1:0]            inj_err,
   input  logic                  clear_counters,
   output logic [Nbits_data-1:0] data_out,
   output logic                  data_valid,
   output logic                  full_signal,
   output logic                  empty_signal,
   output logic                  almost_full,
   output logic [bits_ptr:0]     occupancy,
   output logic                  overflow,
   output logic                  sec_error,
   output logic                  ded_error,
   output logic [7:0]            sec_count,
   output logic [7:0]            ded_count
);

   // Codeword: bit 0 overall parity, Hamming parity at powers of two, data elsewhere.
   localparam int                  Nbits_code = Nbits_data + Nbits_par + 1;
   localparam logic [Nbits_par-1:0] syn_max   = Nbits_par'(Nbits_code - 1);
   localparam logic [bits_ptr:0]   depth_cnt  = (bits_ptr + 1)'(FifoDepth);

   // Build a codeword: scatter data LSB-first over non-power-of-two positions,
   // then fill Hamming parity and finally the overall even parity at bit 0.
   function automatic logic [Nbits_code-1:0] encode(input logic [Nbits_data-1:0] d);
      logic [Nbits_code-1:0] c;
      int k;
      c = '0;
      k = 0;
      for (int i = 1; i < Nbits_code; i++) begin
         if ((i & (i - 1)) != 0) begin
            c[i] = d[k];
            k++;
         end
      end
      for (int p = 0; p < Nbits_par; p++) begin
         for (int i = 1; i < Nbits_code; i++) begin
            if ((((i >> p) & 1) == 1) && (i != (1 << p))) begin
               c[1 << p] = c[1 << p] ^ c[i];
            end
         end
      end
      c[0] = ^c;
      return c;
   endfunction

   // Gather data bits back out of a (possibly corrected) codeword.
   function automatic logic [Nbits_data-1:0] extract(input logic [Nbits_code-1:0] c);
      logic [Nbits_data-1:0] d;
      int k;
      d = '0;
      k = 0;
      for (int i = 1; i < Nbits_code; i++) begin
         if ((i & (i - 1)) != 0) begin
            d[k] = c[i];
            k++;
         end
      end
      return d;
   endfunction

   logic [Nbits_code-1:0] mem [FifoDepth];
   logic [bits_ptr-1:0]   wr_ptr;
   logic [bits_ptr-1:0]   rd_ptr;
   logic [bits_ptr:0]     count;

   logic                  wr_en;
   logic                  rd_en;
   logic                  drop;
   logic [Nbits_code-1:0] wr_code;
   logic [Nbits_code-1:0] rd_code;
   logic [Nbits_code-1:0] corr_code;
   logic [Nbits_par-1:0]  syndrome;
   logic                  par_err;
   logic                  dec_sec;
   logic                  dec_ded;
   logic [Nbits_data-1:0] dec_data;

   assign full_signal  = (count == depth_cnt);
   assign empty_signal = (count == '0);
   assign almost_full  = (count >= af_threshold);
   assign occupancy    = count;

   // A full FIFO still accepts a write when a read frees the head slot in the same cycle.
   assign wr_en = write_signal & (~full_signal | read_signal);
   assign rd_en = read_signal & ~empty_signal;
   assign drop  = write_signal & full_signal & ~read_signal;

   // Encode incoming word and apply test-time error injection before storage.
   always_comb begin
      wr_code = encode(data_in);
      case (inj_err)
         2'b01: wr_code[3] = ~wr_code[3];
         2'b10: begin
            wr_code[3] = ~wr_code[3];
            wr_code[5] = ~wr_code[5];
         end
         default: ;
      endcase
   end

   // Decode the head word: syndrome plus overall parity select clean / corrected / uncorrectable.
   always_comb begin
      rd_code  = mem[rd_ptr];
      syndrome = '0;
      for (int i = 1; i < Nbits_code; i++) begin
         if (rd_code[i]) begin
            syndrome = syndrome ^ Nbits_par'(i);
         end
      end
      par_err   = ^rd_code;
      corr_code = rd_code;
      dec_sec   = 1'b0;
      dec_ded   = 1'b0;
      if (par_err) begin
         if (syndrome == '0) begin
            dec_sec = 1'b1;
         end else if (syndrome <= syn_max) begin
            corr_code[syndrome] = ~corr_code[syndrome];
            dec_sec             = 1'b1;
         end else begin
            dec_ded = 1'b1;
         end
      end else if (syndrome != '0) begin
         dec_ded = 1'b1;
      end
      dec_data = extract(corr_code);
   end

   // Storage array; contents survive reset, only the pointers are cleared.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem[wr_ptr] <= wr_code;
      end
   end

   // Pointers and occupancy; pointers wrap naturally at FifoDepth.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Registered read port: decoded head on a real read, idle pattern on an empty read, hold otherwise.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         data_out   <= idle_pattern;
         data_valid <= 1'b0;
         sec_error  <= 1'b0;
         ded_error  <= 1'b0;
      end else begin
         sec_error <= rd_en & dec_sec;
         ded_error <= rd_en & dec_ded;
         if (read_signal) begin
            if (rd_en) begin
               data_out   <= dec_data;
               data_valid <= 1'b1;
            end else begin
               data_out   <= idle_pattern;
               data_valid <= 1'b0;
            end
         end
      end
   end

   // Saturating error counters and sticky overflow; a clear beats a same-cycle event.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         sec_count <= '0;
         ded_count <= '0;
         overflow  <= 1'b0;
      end else if (clear_counters) begin
         sec_count <= '0;
         ded_count <= '0;
         overflow  <= 1'b0;
      end else begin
         if (rd_en && dec_sec && (sec_count != 8'hFF)) begin
            sec_count <= sec_count + 8'd1;
         end
         if (rd_en && dec_ded && (ded_count != 8'hFF)) begin
            ded_count <= ded_count + 8'd1;
         end
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ldtu_ofifo_secded.sv
// tb/tb_ldtu_ofifo_secded.sv - self-checking bench for ldtu_ofifo_secded
module tb_ldtu_ofifo_secded;

   localparam logic [31:0] IDLE  = 32'hEAAAAAAA;
   localparam int          DEPTH = 16;

   logic        CLK = 1'b0;
   logic        reset;
   logic        write_signal;
   logic [31:0] data_in;
   logic        read_signal;
   logic [4:0]  af_threshold;
   logic [1:0]  inj_err;
   logic        clear_counters;
   logic [31:0] data_out;
   logic        data_valid;
   logic        full_signal;
   logic        empty_signal;
   logic        almost_full;
   logic [4:0]  occupancy;
   logic        overflow;
   logic        sec_error;
   logic        ded_error;
   logic [7:0]  sec_count;
   logic [7:0]  ded_count;

   ldtu_ofifo_secded dut (
      .CLK(CLK), .reset(reset), .write_signal(write_signal), .data_in(data_in),
      .read_signal(read_signal), .af_threshold(af_threshold), .inj_err(inj_err),
      .clear_counters(clear_counters), .data_out(data_out), .data_valid(data_valid),
      .full_signal(full_signal), .empty_signal(empty_signal), .almost_full(almost_full),
      .occupancy(occupancy), .overflow(overflow), .sec_error(sec_error),
      .ded_error(ded_error), .sec_count(sec_count), .ded_count(ded_count)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] data;
      logic        sec;
      logic        ded;
   } exp_t;

   typedef struct {
      logic [31:0] din;
      logic [1:0]  inj;
      logic [31:0] dout;
      logic        sec;
      logic        ded;
   } vec_t;

   exp_t        sb[$];
   vec_t        tbl[8];
   int          n_chk  = 0;
   int          n_pass = 0;

   logic [31:0] m_out;
   logic        m_valid;
   logic        m_ovf;
   logic        m_sec;
   logic        m_ded;
   int          m_sec_cnt;
   int          m_ded_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
   endtask

   task automatic check_all();
      chk("data_out", data_out, m_out);
      chk("data_valid", {31'd0, data_valid}, {31'd0, m_valid});
      chk("occupancy", {27'd0, occupancy}, sb.size());
      chk("full", {31'd0, full_signal}, {31'd0, sb.size() == DEPTH});
      chk("empty", {31'd0, empty_signal}, {31'd0, sb.size() == 0});
      chk("almost_full", {31'd0, almost_full}, {31'd0, sb.size() >= int'(af_threshold)});
      chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      chk("sec_error", {31'd0, sec_error}, {31'd0, m_sec});
      chk("ded_error", {31'd0, ded_error}, {31'd0, m_ded});
      chk("sec_count", {24'd0, sec_count}, m_sec_cnt);
      chk("ded_count", {24'd0, ded_count}, m_ded_cnt);
   endtask

   // One clock: drive inputs, update the scoreboard model, then compare after the edge.
   task automatic cycle(input logic wr, input logic [31:0] d, input logic rd,
                        input logic [1:0] inj, input logic clr);
      int   n;
      exp_t e;
      write_signal   = wr;
      data_in        = d;
      read_signal    = rd;
      inj_err        = inj;
      clear_counters = clr;
      n     = sb.size();
      m_sec = 1'b0;
      m_ded = 1'b0;
      if (rd) begin
         if (n > 0) begin
            e       = sb.pop_front();
            m_out   = e.data;
            m_valid = 1'b1;
            m_sec   = e.sec;
            m_ded   = e.ded;
         end else begin
            m_out   = IDLE;
            m_valid = 1'b0;
         end
      end
      if (wr && (n < DEPTH || rd)) begin
         e.data = (inj == 2'b10) ? (d ^ 32'h3) : d;
         e.sec  = (inj == 2'b01);
         e.ded  = (inj == 2'b10);
         sb.push_back(e);
      end
      if (clr) begin
         m_sec_cnt = 0;
         m_ded_cnt = 0;
         m_ovf     = 1'b0;
      end else begin
         if (m_sec && m_sec_cnt < 255) m_sec_cnt++;
         if (m_ded && m_ded_cnt < 255) m_ded_cnt++;
         if (wr && n == DEPTH && !rd) m_ovf = 1'b1;
      end
      @(posedge CLK);
      #1;
      check_all();
   endtask

   initial begin
      tbl[0] = '{32'h12345678, 2'b01, 32'h12345678, 1'b1, 1'b0};
      tbl[1] = '{32'h12345678, 2'b10, 32'h1234567B, 1'b0, 1'b1};
      tbl[2] = '{32'h00000000, 2'b00, 32'h00000000, 1'b0, 1'b0};
      tbl[3] = '{32'hFFFFFFFF, 2'b01, 32'hFFFFFFFF, 1'b1, 1'b0};
      tbl[4] = '{32'hFFFFFFFF, 2'b10, 32'hFFFFFFFC, 1'b0, 1'b1};
      tbl[5] = '{32'hA5A5A5A5, 2'b11, 32'hA5A5A5A5, 1'b0, 1'b0};
      tbl[6] = '{32'hDEADBEEF, 2'b00, 32'hDEADBEEF, 1'b0, 1'b0};
      tbl[7] = '{32'h00000000, 2'b10, 32'h00000003, 1'b0, 1'b1};

      reset = 1'b0;
      write_signal = 1'b0; data_in = '0; read_signal = 1'b0;
      af_threshold = 5'd16; inj_err = 2'b00; clear_counters = 1'b0;
      m_out = IDLE; m_valid = 1'b0; m_ovf = 1'b0; m_sec = 1'b0; m_ded = 1'b0;
      m_sec_cnt = 0; m_ded_cnt = 0;
      repeat (2) @(posedge CLK);
      #1;
      check_all();
      reset = 1'b1;

      // empty reads return idle
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 2'b00, 1'b0);

      // fill, overflow on the 17th write, drain in order then idle
      for (int i = 0; i < 16; i++) cycle(1'b1, i, 1'b0, 2'b00, 1'b0);
      cycle(1'b1, 32'hBAD0BAD0, 1'b0, 2'b00, 1'b0);
      for (int i = 0; i < 17; i++) cycle(1'b0, '0, 1'b1, 2'b00, 1'b0);
      cycle(1'b0, '0, 1'b0, 2'b00, 1'b1);

      // table: write with injection, read back, compare against fixed expectations
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, tbl[i].din, 1'b0, tbl[i].inj, 1'b0);
         cycle(1'b0, '0, 1'b1, 2'b00, 1'b0);
         chk("tbl_data", data_out, tbl[i].dout);
         chk("tbl_sec", {31'd0, sec_error}, {31'd0, tbl[i].sec});
         chk("tbl_ded", {31'd0, ded_error}, {31'd0, tbl[i].ded});
      end
      cycle(1'b0, '0, 1'b0, 2'b00, 1'b1);

      // read+write while full keeps occupancy, then drain
      for (int i = 0; i < 16; i++) cycle(1'b1, 32'h100 + i, 1'b0, 2'b00, 1'b0);
      cycle(1'b1, 32'hF00D, 1'b1, 2'b00, 1'b0);
      for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, 2'b00, 1'b0);
      // read+write while empty gives idle and occupancy 1
      cycle(1'b1, 32'hCAFE, 1'b1, 2'b00, 1'b0);
      cycle(1'b0, '0, 1'b1, 2'b00, 1'b0);

      // almost_full thresholds 12, 0 and above depth
      af_threshold = 5'd12;
      for (int i = 0; i < 12; i++) cycle(1'b1, 32'h200 + i, 1'b0, 2'b00, 1'b0);
      af_threshold = 5'd0;
      cycle(1'b0, '0, 1'b0, 2'b00, 1'b0);
      af_threshold = 5'd20;
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'h300 + i, 1'b0, 2'b00, 1'b0);
      for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, 2'b00, 1'b0);
      af_threshold = 5'd0;
      cycle(1'b0, '0, 1'b0, 2'b00, 1'b0);
      af_threshold = 5'd16;

      // streaming across pointer wrap
      cycle(1'b1, 32'h4000, 1'b0, 2'b00, 1'b0);
      for (int i = 1; i <= 40; i++) cycle(1'b1, 32'h4000 + i, 1'b1, 2'b00, 1'b0);
      cycle(1'b0, '0, 1'b1, 2'b00, 1'b0);

      // saturation of the single-error counter
      for (int i = 0; i < 300; i++) begin
         cycle(1'b1, $urandom, 1'b0, 2'b01, 1'b0);
         cycle(1'b0, '0, 1'b1, 2'b00, 1'b0);
      end
      chk("sec_saturated", {24'd0, sec_count}, 32'd255);

      // clear together with a sec event and a sticky overflow
      for (int i = 0; i < 16; i++) cycle(1'b1, $urandom, 1'b0, 2'b01, 1'b0);
      cycle(1'b1, 32'h5555, 1'b0, 2'b00, 1'b0);
      cycle(1'b0, '0, 1'b1, 2'b00, 1'b1);
      chk("clr_sec_count", {24'd0, sec_count}, 32'd0);
      chk("clr_overflow", {31'd0, overflow}, 32'd0);
      for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, 2'b00, 1'b0);

      // asynchronous reset mid-operation discards stored words
      for (int i = 0; i < 5; i++) cycle(1'b1, 32'h600 + i, 1'b0, 2'b00, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      sb.delete();
      m_out = IDLE; m_valid = 1'b0; m_ovf = 1'b0; m_sec = 1'b0; m_ded = 1'b0;
      m_sec_cnt = 0; m_ded_cnt = 0;
      check_all();
      @(posedge CLK);
      #1;
      reset = 1'b1;
      cycle(1'b0, '0, 1'b1, 2'b00, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
